// File: rtl/ternary_weight_loader_if.sv
// rtl/ternary_weight_loader_if.sv - load handshake, config and weight bank bundle for ternary_weight_loader
interface ternary_weight_loader_if #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2,
    parameter int IN_BITS     = $clog2(MAX_IN_LEN),
    parameter int OUT_BITS    = $clog2(MAX_OUT_LEN)
);
    logic                                   start;
    logic                                   abort;
    logic [IN_BITS-1:0]                     cfg_in_len_m1;
    logic [OUT_BITS-1:0]                    cfg_out_len_m1;
    logic [MAX_IN_LEN-1:0]                  in_data;
    logic                                   in_valid;
    logic                                   in_ready;
    logic                                   busy;
    logic                                   done;
    logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights;

    modport master (
        output start, abort, cfg_in_len_m1, cfg_out_len_m1, in_data, in_valid,
        input  in_ready, busy, done, weights
    );

    modport slave (
        input  start, abort, cfg_in_len_m1, cfg_out_len_m1, in_data, in_valid,
        output in_ready, busy, done, weights
    );
endinterface

// File: rtl/ternary_weight_loader.sv
// rtl/ternary_weight_loader.sv - double-buffered ternary weight bank loaded one bit-plane beat per cycle
module ternary_weight_loader #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2,
    parameter int IN_BITS     = $clog2(MAX_IN_LEN),
    parameter int OUT_BITS    = $clog2(MAX_OUT_LEN),
    parameter int WB          = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ternary_weight_loader_if.slave   bus
);
    localparam int TOTAL = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;
    localparam int NB    = $clog2(TOTAL);
    localparam int KB    = OUT_BITS + WB;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t              state, state_d;
    logic [IN_BITS-1:0]  cfg_in_q;
    logic [OUT_BITS-1:0] cfg_out_q;
    logic [KB-1:0]       k;
    logic [KB-1:0]       last_k;
    logic [TOTAL-1:0]    shadow, shadow_d;
    logic [TOTAL-1:0]    active;
    logic                done_q;
    logic                beat;
    logic                in_ready_c;
    int                  col_idx;
    int                  bit_idx;

    // Beat k carries bit-plane (k mod WIDTH) of column k/WIDTH; abort wins over a same-edge beat.
    assign beat    = (state == LOAD) && bus.in_valid && !bus.abort;
    assign last_k  = KB'(cfg_out_q) * KB'(WIDTH) + KB'(WIDTH - 1);
    assign col_idx = int'(k >> WB);
    assign bit_idx = int'(k) % WIDTH;

    always_comb begin
        state_d    = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_d = LOAD;
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.abort)                  state_d = IDLE;
                else if (beat && k == last_k)   state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow;
        if (state == IDLE && bus.start) begin
            shadow_d = '0;
        end else if (beat) begin
            for (int i = 0; i < MAX_IN_LEN; i++) begin
                if (i <= int'(cfg_in_q))
                    shadow_d[NB'((i * MAX_OUT_LEN + col_idx) * WIDTH + bit_idx)] = bus.in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_in_q  <= '0;
            cfg_out_q <= '0;
            k         <= '0;
            shadow    <= '0;
            active    <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_d;
            shadow <= shadow_d;
            done_q <= (state == COMMIT);
            if (state == IDLE && bus.start) begin
                cfg_in_q  <= bus.cfg_in_len_m1;
                cfg_out_q <= bus.cfg_out_len_m1;
                k         <= '0;
            end else if (beat) begin
                k <= k + KB'(1);
            end
            if (state == COMMIT) active <= shadow;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.weights  = active;
endmodule

// File: tb/tb_ternary_weight_loader.sv
// tb/tb_ternary_weight_loader.sv - directed and randomized bench for ternary_weight_loader
module tb_ternary_weight_loader;
    localparam int MI  = 16;
    localparam int MO  = 8;
    localparam int W   = 2;
    localparam int TOT = W * MI * MO;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ternary_weight_loader_if bus ();

    ternary_weight_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int mat[MI][MO];
    logic [TOT-1:0] bank_a = '0;

    task automatic chk(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TOT-1:0] flatten();
        logic [TOT-1:0] f;
        f = '0;
        for (int i = 0; i < MI; i++)
            for (int o = 0; o < MO; o++)
                f[(i * MO + o) * W +: W] = W'(mat[i][o]);
        return f;
    endfunction

    function automatic logic [15:0] beat_data(input int mode, input int k);
        logic [15:0] one;
        one = 16'h0001;
        case (mode)
            1:       return one << k;
            2:       return 16'hFFFF;
            3:       return (k == 0) ? 16'hFFFF : 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_load(input int in_m1, input int out_m1, input int mode, input int gaps,
                            input int abort_at, input bit start_mid, input bit chain,
                            input bit skip_start, input int chain_in, input int chain_out);
        int n, k, cyc, o, b;
        bit v;
        logic [15:0] d;
        logic [TOT-1:0] exp;
        n = (out_m1 + 1) * W;
        for (int i = 0; i < MI; i++)
            for (int j = 0; j < MO; j++) mat[i][j] = 0;
        if (!skip_start) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.cfg_in_len_m1  = 4'(in_m1);
            bus.cfg_out_len_m1 = 3'(out_m1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_in_len_m1  = 4'($urandom);
        bus.cfg_out_len_m1 = 3'($urandom);
        chk("busy_load", bus.busy, 1);
        k = 0;
        cyc = 0;
        while (k < n) begin
            if (cyc > 400) begin
                chk("beat_timeout", 0, 1);
                return;
            end
            v = (gaps == 0) ? 1'b1 : (gaps == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            d = beat_data(mode, k);
            bus.in_valid = v;
            bus.in_data  = d;
            bus.abort    = (abort_at >= 0 && k == abort_at);
            if (start_mid && k == 1) begin
                bus.start = 1'b1;
                bus.cfg_in_len_m1  = 4'd0;
                bus.cfg_out_len_m1 = 3'd0;
            end
            chk("in_ready_load", bus.in_ready, 1);
            @(negedge clk);
            bus.start = 1'b0;
            chk("weights_stable", bus.weights, bank_a);
            chk("no_done_load", bus.done, 0);
            if (bus.abort) begin
                bus.abort = 1'b0;
                bus.in_valid = 1'b0;
                chk("busy_after_abort", bus.busy, 0);
                @(negedge clk);
                chk("no_done_abort", bus.done, 0);
                chk("weights_after_abort", bus.weights, bank_a);
                return;
            end
            if (v) begin
                o = k / W;
                b = k % W;
                for (int i = 0; i <= in_m1; i++)
                    mat[i][o] = (mat[i][o] & ~(1 << b)) | (int'(d[i]) << b);
                k++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("ready_commit", bus.in_ready, 0);
        chk("busy_commit", bus.busy, 1);
        chk("weights_commit", bus.weights, bank_a);
        @(negedge clk);
        exp = flatten();
        chk("done_pulse", bus.done, 1);
        chk("weights_new", bus.weights, exp);
        chk("busy_fall", bus.busy, 0);
        bank_a = exp;
        if (chain) begin
            bus.start = 1'b1;
            bus.cfg_in_len_m1  = 4'(chain_in);
            bus.cfg_out_len_m1 = 3'(chain_out);
        end else begin
            @(negedge clk);
            chk("done_single", bus.done, 0);
        end
    endtask

    initial begin
        logic [TOT-1:0] row_mask;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.cfg_in_len_m1 = '0;
        bus.cfg_out_len_m1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_weights", bus.weights, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;

        run_load(15, 0, 3, 0, -1, 0, 0, 0, 0, 0);
        chk("single_col_const", bus.weights, {16{16'h0001}});

        run_load(15, 7, 1, 1, -1, 0, 0, 0, 0, 0);

        run_load(3, 7, 2, 0, -1, 0, 0, 0, 0, 0);
        row_mask = '0;
        row_mask[63:0] = {64{1'b1}};
        chk("row_mask_const", bus.weights, row_mask);

        run_load(15, 7, 0, 2, -1, 0, 0, 0, 0, 0);
        run_load(15, 7, 2, 2, 5, 0, 0, 0, 0, 0);
        run_load(9, 5, 0, 2, -1, 0, 0, 0, 0, 0);

        run_load(15, 3, 0, 0, -1, 1, 1, 0, 5, 2);
        run_load(5, 2, 0, 2, -1, 0, 0, 1, 0, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_in_len_m1 = 4'd15;
        bus.cfg_out_len_m1 = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.in_data = 16'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        chk("midrst_weights", bus.weights, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.in_ready, 0);
        chk("midrst_done", bus.done, 0);
        bank_a = '0;

        for (int r = 0; r < 4; r++)
            run_load($urandom_range(0, 15), $urandom_range(0, 7), 0, 2, -1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
